// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB datapath.
// Steps each instruction through FETCH..WB, drives datapath controls and counts retirements/cycles.
module multicycle_ctrl #(
  parameter logic [31:0] HALT_WORD = 32'h0000_0000,
  parameter int unsigned MAX_INSTR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic [2:0]  op,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [6:0]  opcode;
  logic [2:0]  state_nxt;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        retire;
  logic        clear;
  logic        set_illegal;
  logic        known_opc;
  logic [31:0] instr_inc;

  assign opcode    = ins[6:0];
  assign instr_inc = instr_cnt + 32'd1;
  assign known_opc = (opcode == OPC_R)     || (opcode == OPC_I)      ||
                     (opcode == OPC_LOAD)  || (opcode == OPC_STORE)  ||
                     (opcode == OPC_BRANCH)|| (opcode == OPC_JAL);

  // ALU controls chosen in EXEC; MEM and WB re-present the same values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OPC_R: begin
        case (ins[14:12])
          3'b000:  alu_op = ins[30] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_I, OPC_LOAD, OPC_STORE: alu_src = 1'b1;
      OPC_BRANCH:                 alu_op  = ALU_SUB;
      default:                    alu_op  = ALU_ADD;
    endcase
  end

  always_comb begin
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Mem2Reg     = 1'b0;
    op          = ALU_ADD;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'b00;
    busy        = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    clear       = 1'b0;
    set_illegal = 1'b0;
    state_nxt   = state;

    case (state)
      S_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        IRWrite   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (ins == HALT_WORD) begin
          state_nxt = S_HALT;
        end else if (known_opc) begin
          state_nxt = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_EXEC: begin
        busy   = 1'b1;
        ALUSrc = alu_src;
        op     = alu_op;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = S_MEM;
          OPC_BRANCH: begin
            PCWrite = 1'b1;
            PCSrc   = zero ? 2'b01 : 2'b00;
            retire  = 1'b1;
          end
          OPC_JAL: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            retire  = 1'b1;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        busy   = 1'b1;
        ALUSrc = alu_src;
        op     = alu_op;
        if (opcode == OPC_LOAD) begin
          MemRead   = 1'b1;
          state_nxt = S_WB;
        end else begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        ALUSrc   = alu_src;
        op       = alu_op;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        if (opcode == OPC_LOAD) begin
          MemRead = 1'b1;
          Mem2Reg = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // The retiring edge also decides whether the retire limit has been reached.
    if (retire) begin
      state_nxt = ((MAX_INSTR != 0) && (instr_inc == MAX_INSTR)) ? S_HALT : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_cnt <= '0;
      cycle_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        instr_cnt <= '0;
        cycle_cnt <= '0;
        illegal   <= 1'b0;
      end else begin
        if (busy)        cycle_cnt <= cycle_cnt + 32'd1;
        if (retire)      instr_cnt <= instr_inc;
        if (set_illegal) illegal   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction control patterns, timing, halt/illegal,
// retire limit and asynchronous reset abort.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, zero;
  logic [31:0] ins;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, IRWrite, PCWrite;
  logic [2:0]  op, state;
  logic [1:0]  PCSrc;
  logic        busy, halted, illegal;
  logic [31:0] instr_cnt, cycle_cnt;

  logic        l_start;
  logic [31:0] l_ins;
  logic        l_RegWrite, l_ALUSrc, l_MemRead, l_MemWrite, l_Mem2Reg, l_IRWrite, l_PCWrite;
  logic [2:0]  l_op, l_state;
  logic [1:0]  l_PCSrc;
  logic        l_busy, l_halted, l_illegal;
  logic [31:0] l_instr_cnt, l_cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .op(op), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .busy(busy), .halted(halted), .illegal(illegal), .state(state),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  multicycle_ctrl #(.MAX_INSTR(3)) dut_lim (
    .clk(clk), .rst_n(rst_n), .start(l_start), .ins(l_ins), .zero(zero),
    .RegWrite(l_RegWrite), .ALUSrc(l_ALUSrc), .MemRead(l_MemRead), .MemWrite(l_MemWrite),
    .Mem2Reg(l_Mem2Reg), .op(l_op), .IRWrite(l_IRWrite), .PCWrite(l_PCWrite), .PCSrc(l_PCSrc),
    .busy(l_busy), .halted(l_halted), .illegal(l_illegal), .state(l_state),
    .instr_cnt(l_instr_cnt), .cycle_cnt(l_cycle_cnt)
  );

  // Control vector layout: RegWrite ALUSrc MemRead MemWrite Mem2Reg IRWrite PCWrite PCSrc[1:0] op[2:0]
  logic [11:0] ctl, l_ctl;
  logic [2:0]  stat, l_stat;
  assign ctl    = {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, IRWrite, PCWrite, PCSrc, op};
  assign l_ctl  = {l_RegWrite, l_ALUSrc, l_MemRead, l_MemWrite, l_Mem2Reg, l_IRWrite, l_PCWrite, l_PCSrc, l_op};
  assign stat   = {busy, halted, illegal};
  assign l_stat = {l_busy, l_halted, l_illegal};

  localparam logic [11:0] C_IDLE  = 12'b000000000010;
  localparam logic [11:0] C_FETCH = 12'b000001000010;

  localparam logic [31:0] W_ADD  = 32'h00A58633;
  localparam logic [31:0] W_SUB  = 32'h40B50533;
  localparam logic [31:0] W_AND  = 32'h00B57533;
  localparam logic [31:0] W_OR   = 32'h00B56533;
  localparam logic [31:0] W_SLT  = 32'h00B52533;
  localparam logic [31:0] W_ADDI = 32'h00150513;
  localparam logic [31:0] W_LW   = 32'h0005A503;
  localparam logic [31:0] W_BEQ  = 32'h00B50463;
  localparam logic [31:0] W_JAL  = 32'h0080006F;
  localparam logic [31:0] W_SW   = 32'h00B52023;
  localparam logic [31:0] W_ILL  = 32'h0000007F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] e);
    check({tag, ".state"}, 32'(state), 32'(e));
  endtask

  task automatic chk_ctl(input string tag, input logic [11:0] e);
    check({tag, ".ctl"}, 32'(ctl), 32'(e));
  endtask

  task automatic chk_stat(input string tag, input logic [2:0] e);
    check({tag, ".stat"}, 32'(stat), 32'(e));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] ei, input logic [31:0] ec);
    check({tag, ".instr_cnt"}, instr_cnt, ei);
    check({tag, ".cycle_cnt"}, cycle_cnt, ec);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic s, input logic [31:0] w, input logic z);
    start = s;
    ins   = w;
    zero  = z;
    #1;
  endtask

  // Called in FETCH; runs one R/I instruction through DECODE, EXEC, WB back to FETCH.
  task automatic run_alu(input string tag, input logic [31:0] w, input logic [11:0] ex_ctl,
                         input logic [11:0] wb_ctl, input logic [31:0] ei, input logic [31:0] ec);
    drive(1'b0, w, 1'b0);
    tick(); chk_state({tag, ".dec"}, 3'd2);
    tick(); chk_state({tag, ".ex"}, 3'd3); chk_ctl({tag, ".ex"}, ex_ctl);
    tick(); chk_state({tag, ".wb"}, 3'd5); chk_ctl({tag, ".wb"}, wb_ctl);
    tick(); chk_state({tag, ".next"}, 3'd1); chk_cnt(tag, ei, ec);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ins = 32'h0; zero = 1'b0;
    l_start = 1'b0; l_ins = W_ADD;
    #12 rst_n = 1'b1;

    // Reset state held with no start
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("rst", 3'd0); chk_ctl("rst", C_IDLE); chk_stat("rst", 3'b000); chk_cnt("rst", 0, 0);
    end

    // R-type add with start held high throughout
    drive(1'b1, W_ADD, 1'b0);
    tick(); chk_state("add.f", 3'd1); chk_ctl("add.f", C_FETCH); chk_stat("add.f", 3'b100);
    tick(); chk_state("add.d", 3'd2); chk_ctl("add.d", C_IDLE);
    tick(); chk_state("add.e", 3'd3); chk_ctl("add.e", 12'b000000000010);
    tick(); chk_state("add.w", 3'd5); chk_ctl("add.w", 12'b100000100010);
    tick(); chk_state("add.n", 3'd1); chk_cnt("add", 1, 4);

    run_alu("sub",  W_SUB,  12'b000000000110, 12'b100000100110, 2, 8);
    run_alu("and",  W_AND,  12'b000000000000, 12'b100000100000, 3, 12);
    run_alu("or",   W_OR,   12'b000000000001, 12'b100000100001, 4, 16);
    run_alu("slt",  W_SLT,  12'b000000000111, 12'b100000100111, 5, 20);
    run_alu("addi", W_ADDI, 12'b010000000010, 12'b110000100010, 6, 24);

    // Load word: 5 cycles
    drive(1'b0, W_LW, 1'b0);
    tick(); chk_state("lw.d", 3'd2);
    tick(); chk_state("lw.e", 3'd3); chk_ctl("lw.e", 12'b010000000010);
    tick(); chk_state("lw.m", 3'd4); chk_ctl("lw.m", 12'b011000000010);
    tick(); chk_state("lw.w", 3'd5); chk_ctl("lw.w", 12'b111010100010);
    tick(); chk_state("lw.n", 3'd1); chk_cnt("lw", 7, 29);

    // beq taken, then not taken: 3 cycles each
    drive(1'b0, W_BEQ, 1'b1);
    tick(); chk_state("beqt.d", 3'd2);
    tick(); chk_state("beqt.e", 3'd3); chk_ctl("beqt.e", 12'b000000101110);
    tick(); chk_state("beqt.n", 3'd1); chk_cnt("beqt", 8, 32);
    drive(1'b0, W_BEQ, 1'b0);
    tick(); chk_state("beqn.d", 3'd2);
    tick(); chk_state("beqn.e", 3'd3); chk_ctl("beqn.e", 12'b000000100110);
    tick(); chk_state("beqn.n", 3'd1); chk_cnt("beqn", 9, 35);

    // JAL
    drive(1'b0, W_JAL, 1'b0);
    tick(); chk_state("jal.d", 3'd2);
    tick(); chk_state("jal.e", 3'd3); chk_ctl("jal.e", 12'b000000110010);
    tick(); chk_state("jal.n", 3'd1); chk_cnt("jal", 10, 38);

    // Store: 4 cycles
    drive(1'b0, W_SW, 1'b0);
    tick(); chk_state("sw.d", 3'd2);
    tick(); chk_state("sw.e", 3'd3); chk_ctl("sw.e", 12'b010000000010);
    tick(); chk_state("sw.m", 3'd4); chk_ctl("sw.m", 12'b010100100010);
    tick(); chk_state("sw.n", 3'd1); chk_cnt("sw", 11, 42);

    // Halt word: 2 busy cycles, no retirement, counters then frozen
    drive(1'b0, 32'h0, 1'b0);
    tick(); chk_state("hlt.d", 3'd2);
    tick(); chk_state("hlt.h", 3'd6); chk_stat("hlt.h", 3'b010); chk_ctl("hlt.h", C_IDLE);
    chk_cnt("hlt", 11, 44);
    tick(); chk_state("hlt.hold", 3'd6); chk_cnt("hlt.hold", 11, 44);

    // Illegal opcode after restart from HALT
    drive(1'b1, W_ILL, 1'b0);
    tick(); chk_state("ill.f", 3'd1); chk_cnt("ill.f", 0, 0);
    drive(1'b0, W_ILL, 1'b0);
    tick(); chk_state("ill.d", 3'd2);
    tick(); chk_state("ill.h", 3'd6); chk_stat("ill.h", 3'b011); chk_cnt("ill.h", 0, 2);

    // Restart clears illegal
    drive(1'b1, W_ADD, 1'b0);
    tick(); chk_state("re.f", 3'd1); chk_stat("re.f", 3'b100); chk_cnt("re.f", 0, 0);
    run_alu("re.add", W_ADD, 12'b000000000010, 12'b100000100010, 1, 4);

    // Reset dropped in MEM of a store aborts without a clock edge
    drive(1'b0, W_SW, 1'b0);
    tick(); tick(); tick();
    chk_state("abort.m", 3'd4); chk_ctl("abort.m", 12'b010100100010);
    rst_n = 1'b0;
    #1;
    chk_state("abort", 3'd0); chk_ctl("abort", C_IDLE); chk_cnt("abort", 0, 0);
    tick();
    rst_n = 1'b1;
    tick(); chk_state("abort.idle", 3'd0);

    // Retire limit of 3 on the second instance
    l_start = 1'b1;
    tick();
    check("lim.f.state", 32'(l_state), 32'd1);
    l_start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("lim.w.state", 32'(l_state), 32'd5);
    check("lim.w.instr_cnt", l_instr_cnt, 32'd2);
    tick();
    check("lim.h.state", 32'(l_state), 32'd6);
    check("lim.h.instr_cnt", l_instr_cnt, 32'd3);
    check("lim.h.cycle_cnt", l_cycle_cnt, 32'd12);
    check("lim.h.stat", 32'(l_stat), 32'b010);
    check("lim.h.ctl", 32'(l_ctl), 32'(C_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
